// File: rtl/pdc_xram_pkg.sv
// Shared constants, address-width derivation and clear-sequencer states
// for the multi-port extended RAM.
package pdc_pkg;

   localparam int unsigned pdc_width = 64;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } pdc_state_e;

   // Address width for a given entry count, never narrower than one bit.
   function automatic int unsigned pdc_aw(input int unsigned depth);
      int unsigned w;
      w = 1;
      while ((64'(1) << w) < 64'(depth)) w++;
      return w;
   endfunction

endpackage

// File: rtl/pdc_xram_init.sv
// Clear sequencer: zeroes one entry per cycle after reset, then idles in RUN.
module pdc_xram_init
   import pdc_pkg::*;
#(
   parameter int unsigned DEPTH = 2048,
   parameter int unsigned AW    = pdc_aw(DEPTH)
)(
   input  logic          clk,
   input  logic          rst,
   output logic [AW-1:0] o_clr_addr,
   output logic          o_clr_we,
   output logic          o_busy
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   pdc_state_e    r_state;
   pdc_state_e    w_state_nxt;
   logic [AW-1:0] r_cnt;
   logic [AW-1:0] w_cnt_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= CLEAR;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      o_clr_we    = 1'b0;
      o_busy      = 1'b0;
      case (r_state)
         CLEAR: begin
            o_clr_we = 1'b1;
            o_busy   = 1'b1;
            if (r_cnt == LAST) begin
               w_state_nxt = RUN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + AW'(1);
            end
         end
         RUN: begin
            w_state_nxt = RUN;
         end
         default: begin
            w_state_nxt = CLEAR;
         end
      endcase
      // Busy must read high during the reset cycle even if the FSM was in RUN.
      if (rst) o_busy = 1'b1;
   end

   assign o_clr_addr = r_cnt;

endmodule

// File: rtl/pdc_xram.sv
// Multi-port RAM: WR_PORTS writes, RD_PORTS two-stage registered reads with
// optional write forwarding, and a sequenced post-reset clear.
module pdc_xram
   import pdc_pkg::*;
#(
   parameter  int unsigned WIDTH    = pdc_width,
   parameter  int unsigned DEPTH    = 2048,
   parameter  int unsigned RD_PORTS = 3,
   parameter  int unsigned WR_PORTS = 2,
   parameter  int unsigned BYPASS   = 1,
   localparam int unsigned AW       = pdc_aw(DEPTH)
)(
   input  logic                           clk,
   input  logic                           rst,
   input  logic [RD_PORTS-1:0][AW-1:0]    read_addr,
   input  logic [RD_PORTS-1:0]            read_clkEn,
   output logic [RD_PORTS-1:0][WIDTH-1:0] read_data,
   input  logic [WR_PORTS-1:0][AW-1:0]    write_addr,
   input  logic [WR_PORTS-1:0][WIDTH-1:0] write_data,
   input  logic [WR_PORTS-1:0]            write_wen,
   output logic                           init_busy,
   output logic                           wr_collide
);

   logic [WIDTH-1:0]               r_mem [DEPTH];
   logic [RD_PORTS-1:0][AW-1:0]    r_addr_q;
   logic [RD_PORTS-1:0][WIDTH-1:0] r_rdata;
   logic                           r_collide;

   logic [AW-1:0]                  w_clr_addr;
   logic                           w_clr_we;
   logic                           w_busy;
   logic [WR_PORTS-1:0]            w_wr_ok;
   logic                           w_collide;
   logic [RD_PORTS-1:0][WIDTH-1:0] w_rd_nxt;

   function automatic logic in_range(input logic [AW-1:0] a);
      return 32'(a) < DEPTH;
   endfunction

   pdc_xram_init #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_init (
      .clk        (clk),
      .rst        (rst),
      .o_clr_addr (w_clr_addr),
      .o_clr_we   (w_clr_we),
      .o_busy     (w_busy)
   );

   always_comb begin
      w_wr_ok   = '0;
      w_collide = 1'b0;
      for (int unsigned i = 0; i < WR_PORTS; i++) begin
         w_wr_ok[i] = write_wen[i] && !w_busy && in_range(write_addr[i]);
      end
      for (int unsigned i = 0; i < WR_PORTS; i++) begin
         for (int unsigned j = i + 1; j < WR_PORTS; j++) begin
            if (w_wr_ok[i] && w_wr_ok[j] && (write_addr[i] == write_addr[j]))
               w_collide = 1'b1;
         end
      end
   end

   // Ascending port scan: the highest enabled matching port overrides earlier ones.
   always_comb begin
      w_rd_nxt = '0;
      for (int unsigned k = 0; k < RD_PORTS; k++) begin
         if (!w_busy && in_range(r_addr_q[k])) begin
            w_rd_nxt[k] = r_mem[r_addr_q[k]];
            if (BYPASS != 0) begin
               for (int unsigned i = 0; i < WR_PORTS; i++) begin
                  if (w_wr_ok[i] && (write_addr[i] == r_addr_q[k]))
                     w_rd_nxt[k] = write_data[i];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_clr_we) r_mem[w_clr_addr] <= '0;
      for (int unsigned i = 0; i < WR_PORTS; i++) begin
         if (w_wr_ok[i]) r_mem[write_addr[i]] <= write_data[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr_q  <= '0;
         r_rdata   <= '0;
         r_collide <= 1'b0;
      end else begin
         for (int unsigned k = 0; k < RD_PORTS; k++) begin
            if (read_clkEn[k]) r_addr_q[k] <= read_addr[k];
         end
         r_rdata   <= w_rd_nxt;
         r_collide <= w_collide;
      end
   end

   assign read_data  = r_rdata;
   assign wr_collide = r_collide;
   assign init_busy  = w_busy;

endmodule

// File: tb/tb_pdc_xram.sv
// Randomized bench for pdc_xram against a behavioural model, plus directed
// literal checks on a second instance with DEPTH=1000 and BYPASS=0.
`timescale 1ns/1ps
module tb_pdc_xram;

   localparam int unsigned W   = 64;
   localparam int unsigned D   = 2048;
   localparam int unsigned RP  = 3;
   localparam int unsigned WP  = 2;
   localparam int unsigned AWA = 11;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [RP-1:0][AWA-1:0] ra;
   logic [RP-1:0]          ren;
   logic [RP-1:0][W-1:0]   rd;
   logic [WP-1:0][AWA-1:0] wa;
   logic [WP-1:0][W-1:0]   wd;
   logic [WP-1:0]          we;
   logic                   busy, coll;

   logic [1:0][9:0]  b_ra;
   logic [1:0]       b_ren;
   logic [1:0][15:0] b_rd;
   logic [1:0][9:0]  b_wa;
   logic [1:0][15:0] b_wd;
   logic [1:0]       b_we;
   logic             b_busy, b_coll;

   pdc_xram dut (
      .clk(clk), .rst(rst),
      .read_addr(ra), .read_clkEn(ren), .read_data(rd),
      .write_addr(wa), .write_data(wd), .write_wen(we),
      .init_busy(busy), .wr_collide(coll)
   );

   pdc_xram #(
      .WIDTH(16), .DEPTH(1000), .RD_PORTS(2), .WR_PORTS(2), .BYPASS(0)
   ) dut_b (
      .clk(clk), .rst(rst),
      .read_addr(b_ra), .read_clkEn(b_ren), .read_data(b_rd),
      .write_addr(b_wa), .write_data(b_wd), .write_wen(b_we),
      .init_busy(b_busy), .wr_collide(b_coll)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: memory contents plus a countdown of remaining clear cycles.
   logic [W-1:0]   m_mem [D];
   logic [AWA-1:0] m_aq  [RP];
   logic [W-1:0]   m_rd  [RP];
   bit             m_coll;
   int             m_left = 0;
   bit             m_valid = 0;
   bit             m_idle;

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < RP; k++) begin
            m_aq[k] = '0;
            m_rd[k] = '0;
         end
         for (int a = 0; a < D; a++) m_mem[a] = '0;
         m_coll  = 0;
         m_left  = D;
         m_valid = 1;
      end else begin
         m_idle = (m_left == 0);
         for (int k = 0; k < RP; k++) begin
            m_rd[k] = '0;
            if (m_idle) begin
               m_rd[k] = m_mem[m_aq[k]];
               for (int i = 0; i < WP; i++)
                  if (we[i] && wa[i] == m_aq[k]) m_rd[k] = wd[i];
            end
         end
         m_coll = 0;
         if (m_idle)
            for (int i = 0; i < WP; i++)
               for (int j = i + 1; j < WP; j++)
                  if (we[i] && we[j] && wa[i] == wa[j]) m_coll = 1;
         if (m_idle)
            for (int i = 0; i < WP; i++)
               if (we[i]) m_mem[wa[i]] = wd[i];
         for (int k = 0; k < RP; k++)
            if (ren[k]) m_aq[k] = ra[k];
         if (m_left > 0) m_left--;
      end
   end

   always @(posedge clk) begin
      #1;
      if (m_valid) begin
         for (int k = 0; k < RP; k++)
            check($sformatf("read_data[%0d]", k), rd[k], m_rd[k]);
         check("wr_collide", coll, m_coll);
         check("init_busy", busy, rst || (m_left > 0));
      end
   end

   task automatic idle_inputs();
      we = '0; wd = '0; ren = '0;
      b_we = '0; b_wd = '0; b_ren = '0;
   endtask

   task automatic rand_a();
      logic [31:0] r;
      for (int i = 0; i < WP; i++) begin
         r = $urandom;
         we[i] = ($urandom_range(0, 3) != 0);
         wa[i] = ($urandom_range(0, 7) == 0) ? r[AWA-1:0] : AWA'($urandom_range(0, 15));
         wd[i] = {$urandom, $urandom};
      end
      for (int k = 0; k < RP; k++) begin
         r = $urandom;
         ren[k] = ($urandom_range(0, 1) != 0);
         ra[k] = ($urandom_range(0, 7) == 0) ? r[AWA-1:0] : AWA'($urandom_range(0, 15));
      end
   endtask

   // Counts clock cycles with init_busy high, starting just after rst falls.
   task automatic count_busy(output int n);
      n = 0;
      #1;
      for (int c = 0; c < 5000; c++) begin
         if (!busy) break;
         n++;
         @(posedge clk);
         #1;
      end
   endtask

   int n;

   initial begin
      ra = '0; wa = '0; b_ra = '0; b_wa = '0;
      idle_inputs();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      count_busy(n);
      check("busy_cycles_after_reset", n, 2048);

      // Every entry reads zero after the clear.
      for (int a = 0; a < D; a += RP) begin
         @(negedge clk);
         for (int k = 0; k < RP; k++) ra[k] = AWA'((a + k) % D);
         ren = '1;
      end
      @(negedge clk);
      ren = '0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < RP; k++) check("zero_after_clear", rd[k], 0);
      check("b_busy_done", b_busy, 0);

      // Write 5 = A5 via port 0 and read 5 on port 1 in the same cycle.
      @(negedge clk);
      we[0] = 1'b1; wa[0] = 11'd5; wd[0] = 64'hA5;
      ra[1] = 11'd5; ren = 3'b010;
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      check("read_latency_2", rd[1], 64'hA5);

      // Held address 9 sees a write: forwarded on A, one edge later on B.
      ra[0] = 11'd9; ren = 3'b001;
      b_ra[0] = 10'd9; b_ren = 2'b01;
      @(negedge clk);
      idle_inputs();
      ra[0] = 11'd100; b_ra[0] = 10'd100;
      we[0] = 1'b1; wa[0] = 11'd9; wd[0] = 64'h33;
      b_we[0] = 1'b1; b_wa[0] = 10'd9; b_wd[0] = 16'h33;
      @(negedge clk);
      idle_inputs();
      check("bypass_same_edge", rd[0], 64'h33);
      check("nobypass_prewrite", b_rd[0], 0);
      @(negedge clk);
      check("nobypass_next_edge", b_rd[0], 16'h33);

      // Both ports write 7; higher port wins and collide pulses once.
      we = 2'b11; wa[0] = 11'd7; wa[1] = 11'd7; wd[0] = 64'h11; wd[1] = 64'h22;
      ra[2] = 11'd7; ren = 3'b100;
      @(negedge clk);
      idle_inputs();
      check("collide_pulse", coll, 1);
      @(negedge clk);
      check("collide_one_cycle", coll, 0);
      check("collide_winner", rd[2], 64'h22);

      // Out-of-range write dropped and read returns zero on the 1000-entry instance.
      b_we = 2'b11; b_wa[0] = 10'd1000; b_wd[0] = 16'hFF;
      b_wa[1] = 10'd999; b_wd[1] = 16'h1234;
      b_ra[1] = 10'd1000; b_ren = 2'b10;
      @(negedge clk);
      idle_inputs();
      b_ra[0] = 10'd999; b_ren = 2'b01;
      @(negedge clk);
      idle_inputs();
      check("oob_read_zero", b_rd[1], 0);
      check("oob_no_collide", b_coll, 0);
      @(negedge clk);
      check("inrange_999", b_rd[0], 16'h1234);
      check("oob_read_still_zero", b_rd[1], 0);

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rand_a();
      end
      @(negedge clk);
      idle_inputs();

      // Reset, let the clear reach entry 500 under random traffic, reset again.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 500; c++) begin
         rand_a();
         @(negedge clk);
      end
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      count_busy(n);
      check("busy_cycles_after_restart", n, 2048);

      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         rand_a();
      end
      @(negedge clk);
      idle_inputs();
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
